// File: rtl/stage_fetch_if.sv
// stage_fetch_if: groups the instruction-memory port, the decode-side
// presentation/handshake and the back-end redirect of the fetch stage.
// master = fetch stage, slave = its environment (imem + decode + back end).
interface stage_fetch_if;
  // instruction memory
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  // decode side
  logic        stall;
  logic        discard;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  // back-end redirect
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, pc, instr, instr_valid,
    input  imem_ready, imem_rvalid, imem_rdata,
    input  stall, discard, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, pc, instr, instr_valid,
    output imem_ready, imem_rvalid, imem_rdata,
    output stall, discard, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/stage_fetch.sv
// stage_fetch: sequential instruction fetch with an in-order response FIFO.
// Issues word reads, buffers {pc, instr} pairs for decode, honours decode's
// stall/discard and restarts on back-end redirects. In-flight responses that
// belong to a killed path are dropped by counting them off against r_kill.
// Optional build macro: FETCH_BYPASS_EN -- a live response arriving while the
// FIFO is empty is presented to decode in the same cycle.
module stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  stage_fetch_if.master bus
);

  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic {RUN, WAIT} state_t;

  state_t            r_state;
  logic              r_live;
  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_resp_pc;
  logic [CW-1:0]     r_out;
  logic [CW-1:0]     r_kill;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [31:0]       r_fifo_pc    [DEPTH];
  logic [31:0]       r_fifo_instr [DEPTH];

  logic              w_flush;
  logic [CW:0]       w_sum;
  logic              w_req;
  logic              w_acc;
  logic              w_rsp_live;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_byp_take;
  logic [CW-1:0]     w_out_next;
  logic [31:0]       w_redir_pc;
  logic [31:0]       w_head_pc;
  logic [31:0]       w_head_instr;

  assign w_flush    = bus.discard | bus.redirect_valid;
  assign w_sum      = {1'b0, r_out} + {1'b0, r_count};
  // r_live keeps the request low while in reset and for the first edge after it
  assign w_req      = r_live & (r_state == RUN) & (w_sum < DEPTH_W) & ~w_flush;
  assign w_acc      = w_req & bus.imem_ready;
  assign w_rsp_live = bus.imem_rvalid & (r_kill == '0) & ~w_flush;
  assign w_empty    = (r_count == '0);
  assign w_pop      = ~w_empty & ~bus.stall;
  assign w_push     = w_rsp_live & ~w_byp_take;
  assign w_out_next = r_out + CW'(w_acc) - CW'(bus.imem_rvalid);
  assign w_redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;
  assign w_head_pc    = r_fifo_pc[r_rd_ptr];
  assign w_head_instr = r_fifo_instr[r_rd_ptr];

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;

`ifdef FETCH_BYPASS_EN
  logic w_byp;
  assign w_byp           = w_empty & w_rsp_live;
  assign w_byp_take      = w_byp & ~bus.stall;
  assign bus.instr_valid = ~w_empty | w_byp;
  assign bus.pc          = ~w_empty ? w_head_pc    : (w_byp ? r_resp_pc      : '0);
  assign bus.instr       = ~w_empty ? w_head_instr : (w_byp ? bus.imem_rdata : '0);
`else
  assign w_byp_take      = 1'b0;
  assign bus.instr_valid = ~w_empty;
  assign bus.pc          = w_empty ? '0 : w_head_pc;
  assign bus.instr       = w_empty ? '0 : w_head_instr;
`endif

  // Control: FSM, fetch/response PCs, outstanding/kill counters, FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_live     <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out      <= '0;
      r_kill     <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_live <= 1'b1;
      r_out  <= w_out_next;
      if (bus.redirect_valid) begin
        r_state    <= RUN;
        r_fetch_pc <= w_redir_pc;
        r_resp_pc  <= w_redir_pc;
        r_kill     <= w_out_next;
        r_count    <= '0;
        r_wr_ptr   <= r_rd_ptr;
      end else if (bus.discard) begin
        r_state <= WAIT;
        r_kill  <= w_out_next;
        // The head (the jump itself) still obeys stall; everything behind it goes.
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
          r_wr_ptr <= r_rd_ptr + PW'(1);
          r_count  <= '0;
        end else if (!w_empty) begin
          r_wr_ptr <= r_rd_ptr + PW'(1);
          r_count  <= CW'(1);
        end
      end else begin
        if (w_acc)
          r_fetch_pc <= r_fetch_pc + 32'd4;
        if (bus.imem_rvalid && (r_kill != '0))
          r_kill <= r_kill - CW'(1);
        if (w_rsp_live)
          r_resp_pc <= r_resp_pc + 32'd4;
        if (w_push)
          r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // FIFO storage: write the returned word with the PC it belongs to
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
      r_fifo_instr[r_wr_ptr] <= bus.imem_rdata;
    end
  end

endmodule
